// File: rtl/uart_pkg.sv
// Shared UART definitions: error-bit positions and the stored receive-beat layout.
package uart_pkg;

    localparam int UART_ERR_OVERFLOW = 0;
    localparam int UART_ERR_FRAMING  = 1;
    localparam int UART_ERR_W        = 2;
    localparam int UART_DATA_W       = 8;

    typedef struct packed {
        logic [UART_ERR_W-1:0]  err;
        logic [UART_DATA_W-1:0] data;
    } uart_beat_t;

    localparam int UART_BEAT_W = $bits(uart_beat_t);

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port with load enable.
module uart_fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // The read register holds its value when not enabled, so the host keeps seeing the last byte.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: show-ahead FIFO with sticky line-error flags and fill level.
// Optional `UART_RX_FIFO_ERRINFO_EN stores the per-byte error bits alongside the data.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic [UART_ERR_W-1:0] in_error,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [UART_DATA_W-1:0] out_data,
    output logic [UART_ERR_W-1:0] out_error,
    input  logic                  flush,
    input  logic                  err_clear,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  almost_full,
    output logic                  ovf_flag,
    output logic                  frm_flag
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_L   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   AFULL_L   = (DEPTH_LOG2+1)'(DEPTH - AFULL_MARGIN);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

`ifdef UART_RX_FIFO_ERRINFO_EN
    localparam int ENTRY_W = UART_BEAT_W;
`else
    localparam int ENTRY_W = UART_DATA_W;
`endif

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  almost_full_q, almost_full_d;
    logic                  ovf_q, ovf_d;
    logic                  frm_q, frm_d;

    logic                  push;
    logic                  pop;
    logic                  store;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    rd_entry;
    logic                  ram_wr_en;

    // Without error storage a framing-error byte completes its handshake but is dropped.
    always_comb begin
        push = in_valid & in_ready_q;
        pop  = out_valid_q & out_ready;
`ifdef UART_RX_FIFO_ERRINFO_EN
        store    = push;
        wr_entry = uart_beat_t'{err: in_error, data: in_data};
`else
        store    = push & ~in_error[UART_ERR_FRAMING];
        wr_entry = in_data;
`endif
    end

    // level_q counts only entries written on earlier edges, so the head becomes visible one
    // edge after its write; the RAM read address is the post-pop pointer.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        out_valid_d   = 1'b0;
        ram_wr_en     = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            ram_wr_en = store;
            if (store) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({store, pop})
                2'b10:   level_d = level_q + LEVEL_ONE;
                2'b01:   level_d = level_q - LEVEL_ONE;
                default: level_d = level_q;
            endcase
            out_valid_d = pop ? (level_q > LEVEL_ONE) : (level_q != '0);
        end
        in_ready_d    = (level_d != DEPTH_L);
        almost_full_d = (level_d >= AFULL_L);
    end

    // Sticky flags follow the handshake, and a set beats a same-cycle clear.
    always_comb begin
        ovf_d = (push & in_error[UART_ERR_OVERFLOW]) | (ovf_q & ~err_clear);
        frm_d = (push & in_error[UART_ERR_FRAMING])  | (frm_q & ~err_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            almost_full_q <= 1'b0;
            ovf_q         <= 1'b0;
            frm_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            almost_full_q <= almost_full_d;
            ovf_q         <= ovf_d;
            frm_q         <= frm_d;
        end
    end

    uart_fifo_ram #(
        .WIDTH  (ENTRY_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_en   (out_valid_d),
        .rd_addr (rd_ptr_d),
        .rd_data (rd_entry)
    );

`ifdef UART_RX_FIFO_ERRINFO_EN
    uart_beat_t head;
    assign head      = rd_entry;
    assign out_data  = head.data;
    assign out_error = head.err;
`else
    assign out_data  = rd_entry;
    assign out_error = '0;
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign level       = level_q;
    assign almost_full = almost_full_q;
    assign ovf_flag    = ovf_q;
    assign frm_flag    = frm_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2   = 4;
    localparam int DEPTH        = 16;
    localparam int AFULL_MARGIN = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  in_ready;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic [1:0]            in_error;
    logic                  out_ready;
    logic                  out_valid;
    logic [7:0]            out_data;
    logic [1:0]            out_error;
    logic                  flush;
    logic                  err_clear;
    logic [DEPTH_LOG2:0]   level;
    logic                  almost_full;
    logic                  ovf_flag;
    logic                  frm_flag;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_ready    (in_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_error    (in_error),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_error   (out_error),
        .flush       (flush),
        .err_clear   (err_clear),
        .level       (level),
        .almost_full (almost_full),
        .ovf_flag    (ovf_flag),
        .frm_flag    (frm_flag)
    );

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model: queue of stored {error,data} entries; the newest one is hidden for one edge.
    logic [9:0] modelQ[$];
    bit         freshM;
    bit         inReadyM;
    logic [7:0] shownData;
    logic [1:0] shownErr;
    bit         ovfM;
    bit         frmM;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int visibleCount();
        return modelQ.size() - (freshM ? 1 : 0);
    endfunction

    task automatic modelReset();
        modelQ.delete();
        freshM    = 0;
        inReadyM  = 0;
        shownData = '0;
        shownErr  = '0;
        ovfM      = 0;
        frmM      = 0;
    endtask

    task automatic checkAll(input string phase);
        logic [1:0] expErr;
`ifdef UART_RX_FIFO_ERRINFO_EN
        expErr = shownErr;
`else
        expErr = 2'b00;
`endif
        checkOutput({phase, " in_ready"},    32'(in_ready),    32'(inReadyM));
        checkOutput({phase, " out_valid"},   32'(out_valid),   32'(visibleCount() > 0));
        checkOutput({phase, " out_data"},    32'(out_data),    32'(shownData));
        checkOutput({phase, " out_error"},   32'(out_error),   32'(expErr));
        checkOutput({phase, " level"},       32'(level),       32'(modelQ.size()));
        checkOutput({phase, " almost_full"}, 32'(almost_full), 32'(modelQ.size() >= DEPTH - AFULL_MARGIN));
        checkOutput({phase, " ovf_flag"},    32'(ovf_flag),    32'(ovfM));
        checkOutput({phase, " frm_flag"},    32'(frm_flag),    32'(frmM));
    endtask

    // Called at a falling edge: drive inputs, advance the model at the rising edge, check at the next fall.
    task automatic applyStimulus(input string phase, input logic iv, input logic [7:0] id,
                                 input logic [1:0] ie, input logic ordy, input logic fl, input logic ec);
        bit wr;
        bit rd;
        bit pushed;
        in_valid  = iv;
        in_data   = id;
        in_error  = ie;
        out_ready = ordy;
        flush     = fl;
        err_clear = ec;
        @(posedge clk);
        wr   = iv && inReadyM;
        rd   = ordy && (visibleCount() > 0);
        ovfM = (wr && ie[0]) || (ovfM && !ec);
        frmM = (wr && ie[1]) || (frmM && !ec);
        if (fl) begin
            modelQ.delete();
            freshM = 0;
        end else begin
            if (rd) void'(modelQ.pop_front());
`ifdef UART_RX_FIFO_ERRINFO_EN
            pushed = wr;
`else
            pushed = wr && !ie[1];
`endif
            if (pushed) modelQ.push_back({ie, id});
            freshM = pushed;
        end
        inReadyM = modelQ.size() < DEPTH;
        if (visibleCount() > 0) begin
            shownData = modelQ[0][7:0];
            shownErr  = modelQ[0][9:8];
        end
        @(negedge clk);
        checkAll(phase);
    endtask

    task automatic idle(input string phase, input int n, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(phase, 1'b0, 8'h00, 2'b00, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_error  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        err_clear = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll("in_reset");
        reset_n = 1'b1;
        idle("post_reset", 1, 1'b0);

        // Single byte: hidden for one edge, then presented; read empties the FIFO.
        applyStimulus("t1_write", 1'b1, 8'h41, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("t1 out_valid_latency", 32'(out_valid), 32'd0);
        idle("t1_show", 1, 1'b0);
        checkOutput("t1 out_data_0x41", 32'(out_data), 32'h41);
        applyStimulus("t1_read", 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("t1 level_empty", 32'(level), 32'd0);

        // Fill to full, hold the 17th beat, free one slot, then drain in order.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("t2_fill", 1'b1, 8'(8'h10 + i), 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("t2 level_full", 32'(level), 32'd16);
        checkOutput("t2 in_ready_full", 32'(in_ready), 32'd0);
        applyStimulus("t2_held", 1'b1, 8'hA7, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus("t2_free", 1'b1, 8'hA7, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus("t2_take", 1'b1, 8'hA7, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("t2 level_after_take", 32'(level), 32'd16);
        idle("t2_drain", 20, 1'b1);

        // Steady state at level 5 with simultaneous read and write across pointer wrap.
        for (int i = 0; i < 5; i++)
            applyStimulus("t3_prime", 1'b1, 8'(8'h30 + i), 2'b00, 1'b0, 1'b0, 1'b0);
        idle("t3_settle", 1, 1'b0);
        for (int i = 0; i < 40; i++)
            applyStimulus("t3_stream", 1'b1, 8'(8'h60 + i), 2'b00, 1'b1, 1'b0, 1'b0);
        checkOutput("t3 level_steady", 32'(level), 32'd5);
        idle("t3_drain", 8, 1'b1);

        // Framing-error byte, then a clear racing another error beat, then a plain clear.
        applyStimulus("t4_frm", 1'b1, 8'h55, 2'b10, 1'b0, 1'b0, 1'b0);
        idle("t4_show", 1, 1'b0);
        checkOutput("t4 frm_flag_set", 32'(frm_flag), 32'd1);
        applyStimulus("t4_race", 1'b1, 8'h66, 2'b10, 1'b0, 1'b0, 1'b1);
        checkOutput("t4 frm_flag_kept", 32'(frm_flag), 32'd1);
        idle("t4_drain", 4, 1'b1);
        applyStimulus("t4_clear", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);

        // Overflow flag and its clear.
        applyStimulus("t5_ovf", 1'b1, 8'h12, 2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("t5 ovf_flag_set", 32'(ovf_flag), 32'd1);
        applyStimulus("t5_clear", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("t5 ovf_flag_clear", 32'(ovf_flag), 32'd0);
        idle("t5_drain", 3, 1'b1);

        // Flush at level 7 with a concurrent write; flags survive.
        applyStimulus("t6_ovf", 1'b1, 8'h70, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 7; i++)
            applyStimulus("t6_fill", 1'b1, 8'(8'h70 + i), 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus("t6_flush", 1'b1, 8'h77, 2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("t6 level_flushed", 32'(level), 32'd0);
        checkOutput("t6 ovf_kept", 32'(ovf_flag), 32'd1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 4; i++)
            applyStimulus("t6_burst", 1'b1, 8'(8'h90 + i), 2'b10, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1 modelReset();
        checkAll("t6_async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        idle("t6_release", 1, 1'b0);

        // Random traffic with varying host speed, occasional flush and clear.
        for (int i = 0; i < 900; i++) begin
            logic       iv;
            logic [7:0] id;
            logic [1:0] ie;
            logic       ordy;
            logic       fl;
            logic       ec;
            int         r;
            int         readPct;
            readPct = (i < 300) ? 30 : ((i < 600) ? 80 : 55);
            iv   = ($urandom_range(0, 99) < 60);
            id   = 8'($urandom);
            r    = $urandom_range(0, 15);
            ie   = (r == 0) ? 2'b01 : ((r == 1) ? 2'b10 : ((r == 2) ? 2'b11 : 2'b00));
            ordy = ($urandom_range(0, 99) < readPct);
            fl   = ($urandom_range(0, 59) == 0);
            ec   = ($urandom_range(0, 29) == 0);
            if (fl) ie = 2'b00;
            applyStimulus("random", iv, id, ie, ordy, fl, ec);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
